// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 little-endian word assembler; word/word_valid present the completed word
// combinationally in the cycle its last byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_vld,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [23:0] acc;

    // Earlier bytes sit in the low lanes, so the first byte lands in word[7:0].
    assign word       = {in_byte, acc};
    assign word_valid = in_vld && (idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
        end else if (clr) begin
            idx <= 2'd0;
        end else if (in_vld) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld) begin
            acc <= {in_byte, acc[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/data/checksum byte frame and writes the
// assembled words sequentially into instruction memory while holding the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t          state;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [ADDR_W:0] word_cnt;
    logic [7:0]      xor_q;
    logic            accept;
    logic            start_ok;
    logic            pk_vld;
    logic            word_valid;
    logic [31:0]     pk_word;
    logic [15:0]     n_rx;

    assign busy      = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                       (state == ST_DATA)   || (state == ST_CSUM);
    assign s_ready   = busy;
    assign core_hold = busy;
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);

    assign accept   = s_valid && s_ready;
    assign start_ok = start && !busy;
    assign pk_vld   = accept && (state == ST_DATA);
    assign n_rx     = {s_data, len_lo};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .in_vld     (pk_vld),
        .in_byte    (s_data),
        .word       (pk_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            word_cnt <= '0;
            xor_q    <= 8'd0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_LEN_LO;
                        word_cnt <= '0;
                        xor_q    <= 8'd0;
                        mem_addr <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo <= s_data;
                        state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len <= n_rx;
                        if (n_rx == 16'd0)
                            state <= ST_CSUM;
                        else if ({1'b0, n_rx} > CAP)
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        xor_q <= xor_q ^ s_data;
                        // Word k is written one cycle after its 4th byte, at address k.
                        if (word_valid) begin
                            mem_we   <= 1'b1;
                            mem_wd   <= pk_word;
                            mem_addr <= word_cnt[ADDR_W-1:0];
                            word_cnt <= word_cnt + 1'b1;
                            if (17'(word_cnt) + 17'd1 == 17'(len))
                                state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept)
                        state <= (s_data == xor_q) ? ST_DONE : ST_ERR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops them.
module tb_imem_loader;

    localparam int ADDR_W = 11;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    bit          in_frame  = 1'b0;
    bit          hold_ok   = 1'b1;
    int unsigned hs_cyc    = 0;
    int unsigned t_first   = 0;
    int unsigned t_end     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (in_frame && !core_hold) hold_ok = 1'b0;
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: addr %0d data %h with no write expected",
                         mem_addr, mem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wd, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_data  = b;
        s_valid = 1'b1;
        guard   = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 50) begin
                $display("FAIL handshake_timeout: s_ready stuck at %0b, expected 1", s_ready);
                $fatal(1, "handshake timeout");
            end
        end
        hs_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_frame = 1'b1;
        hold_ok  = 1'b1;
    endtask

    // mode: 0 back-to-back, 1 idle cycle before every byte, 2 random gaps.
    task automatic send_frame(input int n, input bit bad_csum, input int mode,
                              input int stop_after, input int start_at);
        logic [7:0] bytes[$];
        logic [7:0] csum;
        logic [15:0] n16;
        int gap;
        wr_t w;
        n16  = 16'(n);
        csum = 8'd0;
        bytes.push_back(n16[7:0]);
        bytes.push_back(n16[15:8]);
        if (n <= CAP) begin
            for (int k = 0; k < n; k++)
                for (int j = 0; j < 4; j++) begin
                    bytes.push_back(words[k][8*j +: 8]);
                    csum = csum ^ words[k][8*j +: 8];
                end
            bytes.push_back(bad_csum ? (csum ^ 8'h01) : csum);
        end
        for (int i = 0; i < bytes.size(); i++) begin
            if (stop_after >= 0 && i == stop_after) break;
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
                w.addr = ADDR_W'((i - 2) / 4);
                w.data = words[(i - 2) / 4];
                exp_q.push_back(w);
            end
            if (i == start_at) start = 1'b1;
            send_byte(bytes[i], gap);
            start = 1'b0;
            if (i == 0) t_first = hs_cyc;
        end
        in_frame = 1'b0;
    endtask

    task automatic wait_end(input bit exp_done);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!done && !err && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        t_end = cyc;
        check("end_timeout", 32'(guard < 100), 32'd1);
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("core_hold_end", 32'(core_hold), 32'd0);
        check("s_ready_end", 32'(s_ready), 32'd0);
        check("hold_during_load", 32'(hold_ok), 32'd1);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom);
    endtask

    initial begin
        int n;
        bit bad;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reference program, back-to-back
        words = '{32'h00500113, 32'h00C00193, 32'hFF718393};
        do_start();
        check("s_ready_after_start", 32'(s_ready), 32'd1);
        send_frame(3, 1'b0, 0, -1, -1);
        wait_end(1'b1);
        check("latency", t_end - t_first, 32'd15);

        // Same frame with s_valid toggling
        do_start();
        send_frame(3, 1'b0, 1, -1, -1);
        wait_end(1'b1);

        // Empty frames
        words.delete();
        do_start();
        send_frame(0, 1'b0, 0, -1, -1);
        wait_end(1'b1);
        do_start();
        send_frame(0, 1'b1, 0, -1, -1);
        wait_end(1'b0);

        // Oversized length, then recovery with N=1
        do_start();
        send_frame(CAP + 1, 1'b0, 0, -1, -1);
        wait_end(1'b0);
        random_words(1);
        do_start();
        send_frame(1, 1'b0, 2, -1, -1);
        wait_end(1'b1);

        // start pulsed mid-data is ignored
        random_words(3);
        do_start();
        send_frame(3, 1'b0, 0, -1, 7);
        wait_end(1'b1);

        // start in DONE begins a new load immediately
        random_words(2);
        do_start();
        check("done_drops", 32'(done), 32'd0);
        check("busy_after_restart", 32'(busy), 32'd1);
        send_frame(2, 1'b0, 0, -1, -1);
        wait_end(1'b1);

        // Reset after the 6th byte: one write seen, outputs cleared at once
        random_words(2);
        do_start();
        send_frame(2, 1'b0, 0, 6, -1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        check("reset_writes_seen", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        random_words(2);
        do_start();
        send_frame(2, 1'b0, 0, -1, -1);
        wait_end(1'b1);

        // Random frames with random gaps and occasional bad checksum
        for (int r = 0; r < 8; r++) begin
            n   = int'($urandom_range(1, 8));
            bad = ($urandom_range(0, 3) == 0);
            random_words(n);
            do_start();
            send_frame(n, bad, 2, -1, -1);
            wait_end(!bad);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the write side of the instruction memory. It accepts a framed little-endian byte stream over a valid/ready handshake and assembles it into 32-bit words. It writes those words sequentially into the 2K×32 instruction BSRAM through its write port, and holds the core in reset while loading. It sits between a host byte source (UART receiver or debug bridge) and the instruction-memory write port.

## Interface
- ADDR_W, 11, word-address width of instruction memory; capacity 2**ADDR_W words
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle pulse, begins a load; honoured only in IDLE, DONE, ERR
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts byte; transfer when s_valid && s_ready
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  word address of current write
- mem_wd  out  32  word to write
- core_hold  out  1  high while a load is in progress; keeps core in reset
- busy  out  1  high in LEN_LO, LEN_HI, DATA, CSUM
- done  out  1  level, high in DONE
- err  out  1  level, high in ERR

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes, then 1 checksum byte.
- Data words are little-endian: the first byte of each group goes to mem_wd[7:0].
- Checksum = XOR of all 4·N data bytes; length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start → LEN_LO. Clears byte counter, word counter, running XOR, and mem_addr.
- LEN_LO + byte → LEN_HI.
- LEN_HI + byte:
  - N == 0 → CSUM.
  - N > 2**ADDR_W → ERR.
  - otherwise → DATA.
- DATA: every accepted byte shifts into the word register and updates the XOR.
  - 4th byte of a group → registered write next cycle; word counter increments.
  - Word counter reaching N → CSUM.
- CSUM + byte: equal to running XOR → DONE, else → ERR.
- start while busy is ignored.
- s_ready is high in LEN_LO, LEN_HI, DATA, CSUM; low otherwise. No backpressure is needed for writes.
- core_hold is high whenever busy; low in IDLE, DONE, ERR.
- Writes already performed before ERR are not rolled back; memory contents are then undefined to the core.

## Timing
- Reset values: s_ready 0, mem_we 0, mem_addr 0, mem_wd 0, core_hold 0, busy 0, done 0, err 0. State IDLE.
- Reset asserted mid-load: all outputs return to reset values asynchronously. An in-flight mem_we is dropped.
- start at cycle t → state LEN_LO and s_ready = 1 at t+1.
- 4th byte of word k accepted at cycle t → at t+1: mem_we = 1, mem_addr = k, mem_wd = assembled word. mem_we is low at t+2 unless another word completes.
- mem_addr advances by 1 after each write.
  - The highest address written is N−1 ≤ 2**ADDR_W − 1; the address never wraps.
  - The word counter is ADDR_W+1 bits wide.
- Checksum byte may be accepted in the same cycle as the final mem_we.
- Checksum accepted at t → done or err high at t+1; core_hold low at t+1.
- Back-to-back bytes (s_valid held high): one byte per cycle, a word every 4 cycles. Total latency = 4N + 3 cycles from first handshake to done.
- s_valid may drop at any point. State and partial word are held indefinitely; there is no timeout.

## Structure
- Package imem_loader_pkg:
  - state enum (7 states)
  - LEN_BYTES = 2
  - BYTES_PER_WORD = 4
- Sub-module byte_packer: 8→32 little-endian shift assembler with 2-bit byte index, clear input, and word_valid pulse. The FSM, counters, and checksum stay in imem_loader.

## Test plan
- N=3, bytes 13 01 50 00 | 93 01 C0 00 | 93 83 71 FF, correct XOR checksum, s_valid always high:
  - writes 0x00500113@0, 0x00C00193@1, 0xFF718393@2
  - done at cycle 15 after first handshake
  - core_hold high throughout
- Same frame with s_valid toggling every other cycle → identical writes and addresses; no duplicate or lost bytes.
- N=0, checksum 0x00 → no mem_we, done. Checksum 0x01 → err.
- N=0x0801 (> 2048) → ERR after LEN_HI, zero writes, s_ready low. Then start plus a valid N=1 frame → done, writes address 0.
- N=2, reset driven low after the 6th byte → all outputs at reset values immediately, exactly one write observed (address 0). Start plus a fresh frame restarts at address 0.
- start pulsed during DATA → ignored; load completes normally. start in DONE → new load, done drops the next cycle.
